// File: rtl/tone_sequencer.sv
// rtl/tone_sequencer.sv - note-stream tone sequencer: fetch, play, rest, end-of-song
module tone_sequencer #(
    parameter int BEAT_CYCLES = 1000000,
    parameter int GAP_CYCLES  = 100000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        stop,
    input  logic        note_valid,
    input  logic [13:0] note_data,
    output logic        note_ready,
    output logic [5:0]  tone,
    input  logic [13:0] sixty_fourth_period,
    output logic [5:0]  step,
    output logic        step_strobe,
    output logic        square,
    output logic        busy,
    output logic        done,
    output logic        err
);

    localparam int BW = (BEAT_CYCLES > 1) ? $clog2(BEAT_CYCLES) : 1;
    localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam logic [BW-1:0] BEAT_LAST = BW'(BEAT_CYCLES - 1);
    localparam logic [GW-1:0] GAP_LAST  = GW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
    localparam bit HAS_GAP = (GAP_CYCLES > 0);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_PLAY,
        S_GAP,
        S_DONE
    } state_t;

    state_t          state;
    state_t          state_next;
    logic [5:0]      tone_q;
    logic [7:0]      beats_left;
    logic [13:0]     period_cnt;
    logic [5:0]      step_q;
    logic [BW-1:0]   beat_cnt;
    logic [GW-1:0]   gap_cnt;

    logic [5:0]      note_tone;
    logic [7:0]      note_beats;
    logic            tone_bad;
    logic [13:0]     period_last;
    logic            period_wrap;
    logic            beat_wrap;
    logic            gap_wrap;

    assign note_tone  = note_data[13:8];
    assign note_beats = note_data[7:0];
    assign tone_bad   = (note_tone == 6'd0) || (note_tone > 6'd48);
    // A zero period from the table is treated as one so the phase never stalls.
    assign period_last = (sixty_fourth_period == 14'd0) ? 14'd0 : sixty_fourth_period - 14'd1;
    assign period_wrap = (period_cnt >= period_last);
    assign beat_wrap   = (beat_cnt == BEAT_LAST);
    assign gap_wrap    = (gap_cnt == GAP_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next  = state;
        note_ready  = 1'b0;
        tone        = 6'd0;
        step        = 6'd0;
        step_strobe = 1'b0;
        square      = 1'b0;
        busy        = (state != S_IDLE);
        done        = 1'b0;
        case (state)
            S_IDLE: begin
                if (start) state_next = S_FETCH;
            end
            S_FETCH: begin
                note_ready = 1'b1;
                if (note_valid) begin
                    if (note_beats == 8'd0) state_next = S_DONE;
                    else if (!tone_bad)     state_next = S_PLAY;
                end
            end
            S_PLAY: begin
                tone        = tone_q;
                step        = step_q;
                step_strobe = period_wrap;
                square      = step_q[5];
                if (beat_wrap && beats_left == 8'd1) begin
                    state_next = HAS_GAP ? S_GAP : S_FETCH;
                end
            end
            S_GAP: begin
                if (gap_wrap) state_next = S_FETCH;
            end
            S_DONE: begin
                done       = 1'b1;
                state_next = S_IDLE;
            end
            default: state_next = S_IDLE;
        endcase
        if (stop) state_next = S_IDLE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tone_q     <= 6'd0;
            beats_left <= 8'd0;
            period_cnt <= 14'd0;
            step_q     <= 6'd0;
            beat_cnt   <= '0;
            gap_cnt    <= '0;
            err        <= 1'b0;
        end else begin
            if (state == S_PLAY && state_next == S_PLAY) begin
                if (period_wrap) begin
                    period_cnt <= 14'd0;
                    step_q     <= step_q + 6'd1;
                end else begin
                    period_cnt <= period_cnt + 14'd1;
                end
                if (beat_wrap) begin
                    beat_cnt   <= '0;
                    beats_left <= beats_left - 8'd1;
                end else begin
                    beat_cnt <= beat_cnt + BW'(1);
                end
            end else begin
                period_cnt <= 14'd0;
                step_q     <= 6'd0;
                beat_cnt   <= '0;
            end

            if (state == S_FETCH && state_next == S_PLAY) begin
                tone_q     <= note_tone;
                beats_left <= note_beats;
            end else if (state_next == S_IDLE) begin
                tone_q     <= 6'd0;
                beats_left <= 8'd0;
            end

            if (state == S_GAP && state_next == S_GAP) gap_cnt <= gap_cnt + GW'(1);
            else                                       gap_cnt <= '0;

            // Sticky until a new song is started; cleared only by an accepted start.
            if (state == S_IDLE && state_next == S_FETCH) begin
                err <= 1'b0;
            end else if (state == S_FETCH && note_valid && !stop
                         && note_beats != 8'd0 && tone_bad) begin
                err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_tone_sequencer.sv
// tb/tb_tone_sequencer.sv - scoreboard bench for tone_sequencer with randomized songs
module tb_tone_sequencer;
    localparam int BEAT = 100;
    localparam int GAP  = 10;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        stop = 1'b0;
    logic        note_valid = 1'b0;
    logic [13:0] note_data = 14'd0;
    logic        note_ready;
    logic [5:0]  tone;
    logic [13:0] sixty_fourth_period;
    logic [5:0]  step;
    logic        step_strobe;
    logic        square;
    logic        busy;
    logic        done;
    logic        err;

    bit force_en = 1'b0;
    int force_val = 0;

    typedef struct {
        int kind;      // 0 = played note, 1 = done pulse
        int tone;
        int len;
        int strobes;
        int gap;       // -1 = gap not checked
    } exp_t;
    exp_t sb[$];

    int checks = 0;
    int failures = 0;

    function automatic int lut_tbl(input int t);
        return (t == 48) ? 791 : (t * 7 + 2);
    endfunction

    function automatic int period_for(input int t);
        int p;
        p = force_en ? force_val : lut_tbl(t);
        return (p == 0) ? 1 : p;
    endfunction

    assign sixty_fourth_period = force_en ? 14'(force_val) : 14'(lut_tbl(int'(tone)));

    tone_sequencer #(.BEAT_CYCLES(BEAT), .GAP_CYCLES(GAP)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .stop(stop),
        .note_valid(note_valid), .note_data(note_data), .note_ready(note_ready),
        .tone(tone), .sixty_fourth_period(sixty_fourth_period), .step(step),
        .step_strobe(step_strobe), .square(square), .busy(busy), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", name, act, req);
        end
    endtask

    // Monitor: reconstructs played segments, gaps and done pulses from the pins.
    bit   in_seg = 0, in_gap = 0, chk_after_done = 0;
    int   seg_tone, seg_len, seg_str, step_bad, sq_bad, gap_len, exp_gap;
    int   idle_bad = 0;
    exp_t mon_e;

    always @(negedge clk) begin
        if (chk_after_done) begin
            check("busy_after_done", int'(busy), 0);
            check("done_width", int'(done), 0);
            chk_after_done = 0;
        end
        if (tone != 6'd0) begin
            if (!in_seg) begin
                in_seg = 1; in_gap = 0;
                seg_tone = int'(tone); seg_len = 0; seg_str = 0; step_bad = 0; sq_bad = 0;
            end
            if (int'(step) != seg_str % 64) step_bad++;
            if (square != step[5]) sq_bad++;
            seg_len++;
            seg_str += int'(step_strobe);
        end else begin
            if (busy && (step != 6'd0 || square || step_strobe)) idle_bad++;
            if (in_seg) begin
                in_seg = 0;
                if (sb.size() == 0 || sb[0].kind != 0) begin
                    checks++; failures++;
                    $display("FAIL unexpected_note actual=tone%0d len%0d required=none", seg_tone, seg_len);
                    exp_gap = -1;
                end else begin
                    mon_e = sb.pop_front();
                    check("seg_tone", seg_tone, mon_e.tone);
                    check("seg_len", seg_len, mon_e.len);
                    check("seg_strobes", seg_str, mon_e.strobes);
                    check("seg_step_seq", step_bad, 0);
                    check("seg_square", sq_bad, 0);
                    exp_gap = mon_e.gap;
                end
                in_gap = 1; gap_len = 0;
            end
            if (in_gap) begin
                if (busy && !note_ready && !done) gap_len++;
                else begin
                    in_gap = 0;
                    if (exp_gap >= 0) check("gap_len", gap_len, exp_gap);
                end
            end
        end
        if (done) begin
            if (sb.size() == 0 || sb[0].kind != 1) begin
                checks++; failures++;
                $display("FAIL unexpected_done actual=1 required=0");
            end else begin
                mon_e = sb.pop_front();
                checks++;
            end
            chk_after_done = 1;
        end
    end

    task automatic do_start();
        @(negedge clk); start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
    endtask

    task automatic send_note(input int t, input int b, input bit push);
        bit ok;
        exp_t e;
        ok = 0;
        note_data = {t[5:0], b[7:0]};
        note_valid = 1'b1;
        for (int i = 0; i < 2000; i++) begin
            @(negedge clk);
            if (note_ready) begin ok = 1; break; end
        end
        if (!ok) check("ready_timeout", 0, 1);
        @(posedge clk); #1 note_valid = 1'b0;
        if (push) begin
            if (b == 0) begin
                e.kind = 1; e.tone = 0; e.len = 0; e.strobes = 0; e.gap = -1;
                sb.push_back(e);
            end else if (t != 0 && t <= 48) begin
                e.kind = 0; e.tone = t; e.len = b * BEAT;
                e.strobes = (b * BEAT) / period_for(t); e.gap = GAP;
                sb.push_back(e);
            end
        end
    endtask

    task automatic wait_idle();
        bit ok;
        ok = 0;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            if (!busy) begin ok = 1; break; end
        end
        if (!ok) check("idle_timeout", 0, 1);
    endtask

    task automatic wait_tone(input bit nonzero);
        bit ok;
        ok = 0;
        for (int i = 0; i < 2000; i++) begin
            @(negedge clk);
            if ((tone != 6'd0) == nonzero) begin ok = 1; break; end
        end
        if (!ok) check("tone_timeout", 0, 1);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_tone"}, int'(tone), 0);
        check({tag, "_step"}, int'(step), 0);
        check({tag, "_strobe"}, int'(step_strobe), 0);
        check({tag, "_square"}, int'(square), 0);
        check({tag, "_ready"}, int'(note_ready), 0);
        check({tag, "_busy"}, int'(busy), 0);
        check({tag, "_done"}, int'(done), 0);
        check({tag, "_err"}, int'(err), 0);
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        exp_t e;
        int   n, t, b, m, activity;
        bit   exp_err;

        #3 check_all_zero("reset");
        @(negedge clk); rst_n = 1'b1;

        // 48 at 791: no strobes within 200 cycles, then 10 rest cycles.
        do_start();
        send_note(48, 2, 1);
        send_note(0, 0, 1);
        wait_idle();

        // Forced period 3: 33 strobes, step reaches 33 and square rises.
        force_en = 1; force_val = 3;
        do_start();
        send_note(10, 1, 1);
        send_note(0, 0, 1);
        wait_idle();

        // Zero period behaves as one: strobe every cycle.
        force_val = 0;
        do_start();
        send_note(7, 1, 1);
        send_note(0, 0, 1);
        wait_idle();
        force_en = 0;

        // Invalid tone is skipped and flags a sticky error until the next start.
        do_start();
        send_note(50, 3, 1);
        check("err_set", int'(err), 1);
        send_note(1, 1, 1);
        send_note(0, 0, 1);
        wait_idle();
        check("err_sticky", int'(err), 1);
        do_start();
        check("err_clear_on_start", int'(err), 0);
        send_note(0, 0, 1);
        wait_idle();

        // Stop in the 40th PLAY cycle aborts without a done pulse.
        do_start();
        send_note(5, 3, 0);
        e.kind = 0; e.tone = 5; e.len = 40; e.strobes = 40 / period_for(5); e.gap = 0;
        sb.push_back(e);
        wait_tone(1);
        repeat (39) @(negedge clk);
        stop = 1'b1;
        @(posedge clk); #1 stop = 1'b0;
        check("stop_tone", int'(tone), 0);
        check("stop_busy", int'(busy), 0);
        repeat (5) @(negedge clk);

        // Stop beats a simultaneous start.
        @(negedge clk); start = 1'b1; stop = 1'b1;
        @(posedge clk); #1 start = 1'b0; stop = 1'b0;
        check("stop_over_start", int'(busy), 0);

        // FETCH holds indefinitely, then stop beats a simultaneous transfer.
        do_start();
        repeat (50) @(negedge clk);
        check("fetch_wait_ready", int'(note_ready), 1);
        check("fetch_wait_busy", int'(busy), 1);
        note_data = {6'd3, 8'd1}; note_valid = 1'b1; stop = 1'b1;
        @(posedge clk); #1 note_valid = 1'b0; stop = 1'b0;
        check("stop_over_transfer", int'(busy), 0);
        repeat (5) @(negedge clk);

        // Asynchronous reset in the middle of a rest; nothing replays afterwards.
        do_start();
        send_note(2, 1, 0);
        e.kind = 0; e.tone = 2; e.len = BEAT; e.strobes = BEAT / period_for(2); e.gap = -1;
        sb.push_back(e);
        wait_tone(1);
        wait_tone(0);
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b0;
        #1 check_all_zero("midgap_reset");
        @(negedge clk); rst_n = 1'b1;
        activity = 0;
        repeat (30) begin
            @(negedge clk);
            if (busy || tone != 6'd0) activity++;
        end
        check("no_replay", activity, 0);

        // Randomized songs with mixed table / forced periods and occasional bad tones.
        for (int s = 0; s < 6; s++) begin
            m = $urandom_range(0, 3);
            force_en = (m != 0);
            force_val = (m == 1) ? 0 : (m == 2) ? int'($urandom_range(1, 60)) : 791;
            exp_err = 0;
            do_start();
            n = $urandom_range(1, 3);
            for (int k = 0; k < n; k++) begin
                case ($urandom_range(0, 9))
                    0:       t = 0;
                    1:       t = $urandom_range(49, 63);
                    default: t = $urandom_range(1, 48);
                endcase
                b = $urandom_range(1, 3);
                if (t == 0 || t > 48) exp_err = 1;
                send_note(t, b, 1);
            end
            send_note(0, 0, 1);
            wait_idle();
            check("rand_err", int'(err), int'(exp_err));
        end
        force_en = 0;
        repeat (3) @(negedge clk);

        check("sb_drained", sb.size(), 0);
        check("idle_outputs_quiet", idle_bad, 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/tone_sequencer.md
TONE_SEQUENCER -- requirements
Module: tone_sequencer

Interface
REQ-001 SHALL have parameter BEAT_CYCLES, default 1000000: clock cycles per duration unit (10 ms at 100 MHz).
REQ-002 SHALL have parameter GAP_CYCLES, default 100000: rest cycles inserted after every played note.
REQ-003 SHALL have port clk  in  1: single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst_n  in  1: asynchronous reset, active-low.
REQ-005 SHALL have port start  in  1: begin sequencing; sampled in IDLE only.
REQ-006 SHALL have port stop  in  1: abort; sampled in every state.
REQ-007 SHALL have port note_valid  in  1: note_data valid.
REQ-008 SHALL have port note_data  in  14: {tone[13:8], beats[7:0]}.
REQ-009 SHALL have port note_ready  out  1: sequencer accepts a note; transfer occurs when note_valid and note_ready are both 1.
REQ-010 SHALL have port tone  out  6: tone index to the period look-up table; 0 = rest.
REQ-011 SHALL have port sixty_fourth_period  in  14: look-up table result for tone, combinational, same cycle.
REQ-012 SHALL have port step  out  6: waveform phase, 0..63.
REQ-013 SHALL have port step_strobe  out  1: one-cycle pulse when step advances.
REQ-014 SHALL have port square  out  1: step[5] in PLAY, else 0.
REQ-015 SHALL have port busy  out  1: state is not IDLE.
REQ-016 SHALL have port done  out  1: one-cycle pulse at end of song.
REQ-017 SHALL have port err  out  1: sticky; set when an invalid tone is received.

Function
REQ-018 SHALL implement states IDLE, FETCH, PLAY, GAP, DONE.
REQ-019 IDLE: note_ready=0, tone=0, step=0; start=1 with stop=0 -> FETCH next cycle; start outside IDLE ignored.
REQ-020 FETCH: note_ready=1, tone=0; on transfer, latch tone/beats in the same edge.
REQ-021 FETCH transfer with beats==0 (end marker) -> DONE; done=1 for exactly the DONE cycle; DONE -> IDLE next cycle.
REQ-022 FETCH transfer with tone==0 or tone>48 and beats!=0 -> set err, remain in FETCH, note discarded.
REQ-023 Otherwise -> PLAY; tone drives latched index from the first PLAY cycle; period counter=0, step=0, beat-cycle counter=0.
REQ-024 PLAY period counter (14-bit): increments each cycle; at count==P-1 wraps to 0, step increments mod 64 (63 wraps to 0), step_strobe=1 that cycle; P = sixty_fourth_period, with 0 treated as 1.
REQ-025 PLAY beat counter: counts 0..BEAT_CYCLES-1; at terminal, remaining beats decrement; when the final beat terminates (beats 1 -> 0) -> GAP; note length = beats*BEAT_CYCLES cycles exactly.
REQ-026 GAP: tone=0, step=0, no strobes, note_ready=0, for GAP_CYCLES cycles, then -> FETCH.
REQ-027 GAP_CYCLES=0 SHALL go PLAY -> FETCH directly.
REQ-028 stop=1 in any state -> IDLE next cycle; counters cleared; no done pulse; stop wins over a simultaneous start or transfer (no note latched).
REQ-029 FETCH waits indefinitely while note_valid=0; outputs held.
REQ-030 err clears only on reset or on a start accepted in IDLE.

Reset
REQ-031 rst_n=0 SHALL immediately force IDLE and tone=0, step=0, step_strobe=0, square=0, note_ready=0, busy=0, done=0, err=0, all counters 0, regardless of clk.
REQ-032 Reset deassertion mid-note SHALL resume in IDLE; no note is replayed.

Verification (BEAT_CYCLES=100, GAP_CYCLES=10)
REQ-033 start; note {48,2}, LUT returns 791 -> tone=48 for 200 cycles, step_strobe every 791 cycles (none within 200), then 10 cycles tone=0, note_ready=1.
REQ-034 LUT forced to 3: note {10,1} -> strobes every 3 cycles, step 0..33 in 100 cycles, square=1 once step>=32.
REQ-035 notes {1,1},{0,0} -> PLAY 100, GAP 10, FETCH, DONE: done high 1 cycle, busy low next cycle.
REQ-036 note {50,3} then {1,1} -> err=1, first note skipped, tone=1 plays; err stays 1 until next start.
REQ-037 stop asserted in cycle 40 of PLAY -> IDLE next cycle, tone=0, no done; rst_n low mid-GAP -> all outputs 0 asynchronously.
REQ-038 LUT returns 0 -> step_strobe every cycle, no lockup.
